// File: rtl/bcd_countdown_timer.sv
// Packed-BCD down-counter with load, start/stop control, an expiry strobe and
// an invalid-load strobe. Digit 0 occupies bits [3:0].
module bcd_countdown_timer #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                zero,
    output logic                expired,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           running_q, running_d;
    logic           expired_q, expired_d;
    logic           load_err_q, load_err_d;

    // True when every nibble of v is a legal BCD digit (0..9).
    function automatic logic is_bcd(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Subtract one in BCD; a zero digit wraps to 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic cnt_zero;
    logic stop_ok;
    logic start_ok;
    logic tick_ok;

    assign cnt_zero = (count_q == '0);
    assign stop_ok  = stop  && (state_q == RUN);
    assign start_ok = start && ((state_q == IDLE) || (state_q == PAUSE)) && !cnt_zero;
    assign tick_ok  = tick  && (state_q == RUN) && !cnt_zero;

    // Next-state and next-count decode; load > stop > start > tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (is_bcd(load_value)) begin
                count_d = load_value;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop_ok) begin
            state_d = PAUSE;
        end else if (start_ok) begin
            state_d = RUN;
        end else if (tick_ok) begin
            count_d = bcd_dec(count_q);
            if (count_q == W'(1)) begin
                state_d   = DONE;
                expired_d = 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    // State, count and strobe registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign zero     = cnt_zero;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule
